mem_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline. Sits directly downstream of EX and upstream of WB.
- Registers the EX→MEM bus and issues loads/stores over a split address/data handshake to the data memory.
- Stalls the pipeline until the memory op completes, then formats load data (lb/lbu/lh/lhu/lw).
- Produces the MEM→WB bus and the MEM→ID forwarding bus.

---
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_stage.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Split address/data handshake between the MEM stage (master) and the data memory (slave).
// The master holds req until addr_ok; the slave answers each accepted request with one data_ok.
interface mem_stage_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: registers the EX->MEM bus, issues one load/store per instruction, formats loads.
// Stall requests are raised from entry until data_ok (at least 2 cycles); the stage holds while stall[3] is set.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 178,
  parameter int MEM_TO_WB_WD = 136,
  parameter int MEM_TO_ID_WD = 104,
  parameter int STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  output logic                    stallreq_for_mem,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
  mem_stage_if.master             dmem
);
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef struct packed {
    logic        inst_h;
    logic        inst_hu;
    logic        inst_b;
    logic        inst_bu;
    logic        hi_we;
    logic [31:0] hi_wdata;
    logic        lo_we;
    logic [31:0] lo_wdata;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [31:0] store_wdata;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        hi_we;
    logic [31:0] hi_wdata;
    logic        lo_we;
    logic [31:0] lo_wdata;
  } mem_wb_t;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  ex_mem_t     r_q;
  logic        done_q;
  logic [31:0] load_buf_q;
  state_t      state_q;
  state_t      state_d;
  logic        mem_op;
  logic        is_byte;
  logic        is_half;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_val;
  mem_wb_t     wb;
  logic        unused_stall;

  assign unused_stall = ^{stall[STALL_WD-1:5], stall[2:0]};
  assign mem_op  = r_q.data_ram_en;
  assign is_byte = r_q.inst_b | r_q.inst_bu;
  assign is_half = r_q.inst_h | r_q.inst_hu;

  // Any register load, bubble included, starts a fresh instruction with no completed access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= '0;
      done_q     <= 1'b0;
      load_buf_q <= '0;
    end else if (stall[3] == STOP && stall[4] == NO_STOP) begin
      r_q        <= '0;
      done_q     <= 1'b0;
      load_buf_q <= '0;
    end else if (stall[3] == NO_STOP) begin
      r_q        <= ex_to_mem_bus;
      done_q     <= 1'b0;
      load_buf_q <= '0;
    end else if (state_q == WAIT && dmem.data_data_ok) begin
      done_q     <= 1'b1;
      load_buf_q <= dmem.data_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dmem.data_req && dmem.data_addr_ok) state_d = WAIT;
      WAIT:    if (dmem.data_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done_q blocks re-issue while an external stall keeps a finished access in the stage.
  always_comb begin
    dmem.data_req    = (state_q == IDLE) && mem_op && !done_q;
    stallreq_for_mem = mem_op && !done_q;
  end

  always_comb begin
    dmem.data_wr    = |r_q.data_ram_wen;
    dmem.data_addr  = r_q.ex_result;
    dmem.data_size  = 2'd0;
    dmem.data_wstrb = 4'b0000;
    dmem.data_wdata = r_q.store_wdata;
    if (is_byte) begin
      dmem.data_wstrb = 4'b0001 << r_q.ex_result[1:0];
      dmem.data_wdata = {4{r_q.store_wdata[7:0]}};
    end else if (is_half) begin
      dmem.data_wstrb = r_q.ex_result[1] ? 4'b1100 : 4'b0011;
      dmem.data_wdata = {2{r_q.store_wdata[15:0]}};
    end else begin
      dmem.data_wstrb = 4'b1111;
    end
    if (mem_op) dmem.data_size = is_byte ? 2'd0 : (is_half ? 2'd1 : 2'd2);
    if (!dmem.data_wr) dmem.data_wstrb = 4'b0000;
  end

  always_comb begin
    case (r_q.ex_result[1:0])
      2'd0:    load_byte = load_buf_q[7:0];
      2'd1:    load_byte = load_buf_q[15:8];
      2'd2:    load_byte = load_buf_q[23:16];
      default: load_byte = load_buf_q[31:24];
    endcase
    load_half = r_q.ex_result[1] ? load_buf_q[31:16] : load_buf_q[15:0];
    load_val  = load_buf_q;
    if (r_q.inst_b)       load_val = {{24{load_byte[7]}}, load_byte};
    else if (r_q.inst_bu) load_val = {24'd0, load_byte};
    else if (r_q.inst_h)  load_val = {{16{load_half[15]}}, load_half};
    else if (r_q.inst_hu) load_val = {16'd0, load_half};
  end

  always_comb begin
    wb.pc       = r_q.pc;
    wb.rf_we    = r_q.rf_we;
    wb.rf_waddr = r_q.rf_waddr;
    wb.rf_wdata = r_q.sel_rf_res ? load_val : r_q.ex_result;
    wb.hi_we    = r_q.hi_we;
    wb.hi_wdata = r_q.hi_wdata;
    wb.lo_we    = r_q.lo_we;
    wb.lo_wdata = r_q.lo_wdata;
  end

  assign mem_to_wb_bus = wb;
  // Forwarding must not offer a register value whose load has not returned yet.
  assign mem_to_id_bus = {wb.rf_we & ~stallreq_for_mem, wb.rf_waddr, wb.rf_wdata,
                          wb.hi_we, wb.hi_wdata, wb.lo_we, wb.lo_wdata};
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: transaction-level model plus hand-computed literal checks.
module tb_mem_stage;
  typedef struct packed {
    logic        inst_h;
    logic        inst_hu;
    logic        inst_b;
    logic        inst_bu;
    logic        hi_we;
    logic [31:0] hi_wdata;
    logic        lo_we;
    logic [31:0] lo_wdata;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [31:0] store_wdata;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        hi_we;
    logic [31:0] hi_wdata;
    logic        lo_we;
    logic [31:0] lo_wdata;
  } mem_wb_t;

  localparam logic [3:0] T_W  = 4'b0000;
  localparam logic [3:0] T_H  = 4'b1000;
  localparam logic [3:0] T_HU = 4'b0100;
  localparam logic [3:0] T_B  = 4'b0010;
  localparam logic [3:0] T_BU = 4'b0001;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic         stallreq;
  ex_mem_t      ex_bus;
  logic [135:0] wb_bus;
  logic [103:0] id_bus;
  logic         ext_hold;
  logic         force_bubble;
  logic         chk_en;
  int           n_checks = 0;
  int           n_fail = 0;
  int           n_hs = 0;

  // model state: instruction in the stage, its request accepted, its data returned
  ex_mem_t      m_ins;
  logic         m_acc;
  logic         m_done;
  logic [31:0]  m_buf;

  mem_wb_t      e_wb;
  logic         e_stall;
  logic         e_req;
  logic [1:0]   e_size;
  logic [3:0]   e_wstrb;
  logic [31:0]  e_wdata;

  mem_stage_if mif();

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .stallreq_for_mem (stallreq),
    .ex_to_mem_bus    (ex_bus),
    .mem_to_wb_bus    (wb_bus),
    .mem_to_id_bus    (id_bus),
    .dmem             (mif)
  );

  always #5 clk = ~clk;

  assign stall = force_bubble ? 6'b001111 : ((ext_hold || stallreq) ? 6'b011111 : 6'b000000);

  task automatic check(input string nm, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fmt_load(input ex_mem_t i, input logic [31:0] w);
    int sh;
    logic [31:0] v;
    v = w;
    if (i.inst_b || i.inst_bu) begin
      sh = 8 * int'(i.ex_result[1:0]);
      v = (w >> sh) & 32'h0000_00FF;
      if (i.inst_b && v[7]) v = v | 32'hFFFF_FF00;
    end else if (i.inst_h || i.inst_hu) begin
      sh = 16 * int'(i.ex_result[1]);
      v = (w >> sh) & 32'h0000_FFFF;
      if (i.inst_h && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic mem_wb_t exp_wb();
    mem_wb_t e;
    e.pc       = m_ins.pc;
    e.rf_we    = m_ins.rf_we;
    e.rf_waddr = m_ins.rf_waddr;
    e.rf_wdata = m_ins.sel_rf_res ? fmt_load(m_ins, m_buf) : m_ins.ex_result;
    e.hi_we    = m_ins.hi_we;
    e.hi_wdata = m_ins.hi_wdata;
    e.lo_we    = m_ins.lo_we;
    e.lo_wdata = m_ins.lo_wdata;
    return e;
  endfunction

  function automatic ex_mem_t mk(input logic [3:0] ty, input logic [3:0] wen,
                                 input logic [31:0] addr, input logic [31:0] sdata);
    ex_mem_t i;
    i = '0;
    {i.inst_h, i.inst_hu, i.inst_b, i.inst_bu} = ty;
    i.hi_we        = 1'b1;
    i.hi_wdata     = 32'hA5A5_0000 ^ addr;
    i.lo_wdata     = ~addr;
    i.pc           = 32'hBFC0_0000 + addr;
    i.data_ram_en  = 1'b1;
    i.data_ram_wen = wen;
    i.sel_rf_res   = (wen == 4'd0);
    i.rf_we        = (wen == 4'd0);
    i.rf_waddr     = 5'd9;
    i.ex_result    = addr;
    i.store_wdata  = sdata;
    return i;
  endfunction

  // Model: one request per instruction; a response only counts if a request is outstanding.
  always @(posedge clk) begin
    if (rst || (stall[3] && !stall[4])) begin
      m_ins = '0; m_acc = 1'b0; m_done = 1'b0; m_buf = '0;
    end else if (!stall[3]) begin
      m_ins = ex_bus; m_acc = 1'b0; m_done = 1'b0; m_buf = '0;
    end else if (m_acc && !m_done && mif.data_data_ok) begin
      m_done = 1'b1;
      m_buf  = mif.data_rdata;
    end else if (m_ins.data_ram_en && !m_acc && mif.data_addr_ok) begin
      m_acc = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      e_wb    = exp_wb();
      e_stall = m_ins.data_ram_en && !m_done;
      e_req   = m_ins.data_ram_en && !m_acc;
      e_size  = !m_ins.data_ram_en ? 2'd0 :
                (m_ins.inst_b || m_ins.inst_bu) ? 2'd0 : (m_ins.inst_h || m_ins.inst_hu) ? 2'd1 : 2'd2;
      if (m_ins.data_ram_wen == 4'd0)           e_wstrb = 4'b0000;
      else if (m_ins.inst_b || m_ins.inst_bu)   e_wstrb = 4'b0001 << m_ins.ex_result[1:0];
      else if (m_ins.inst_h || m_ins.inst_hu)   e_wstrb = m_ins.ex_result[1] ? 4'b1100 : 4'b0011;
      else                                      e_wstrb = 4'b1111;
      if (m_ins.inst_b || m_ins.inst_bu)        e_wdata = {4{m_ins.store_wdata[7:0]}};
      else if (m_ins.inst_h || m_ins.inst_hu)   e_wdata = {2{m_ins.store_wdata[15:0]}};
      else                                      e_wdata = m_ins.store_wdata;
      check("wb_bus", wb_bus, e_wb);
      check("id_bus", id_bus, {e_wb.rf_we && !e_stall, e_wb.rf_waddr, e_wb.rf_wdata,
                               e_wb.hi_we, e_wb.hi_wdata, e_wb.lo_we, e_wb.lo_wdata});
      check("data_req", mif.data_req, e_req);
      check("stallreq", stallreq, e_stall);
      check("data_wr", mif.data_wr, |m_ins.data_ram_wen);
      check("data_size", mif.data_size, e_size);
      check("data_wstrb", mif.data_wstrb, e_wstrb);
      check("data_addr", mif.data_addr, m_ins.ex_result);
      check("data_wdata", mif.data_wdata, e_wdata);
      if (!rst && mif.data_req && mif.data_addr_ok) n_hs++;
    end
  end

  task automatic do_mem(input string nm, input ex_mem_t ins, input int ad, input logic [31:0] rd,
                        input int hold, input logic [31:0] x_rf, input logic [1:0] x_size,
                        input logic [3:0] x_wstrb, input logic [31:0] x_wdata);
    int n_stall;
    int n_req;
    int hs0;
    mem_wb_t w;
    n_stall = 0; n_req = 0; hs0 = n_hs;
    ex_bus = ins;
    step();
    ex_bus = '0;
    for (int c = 0; c <= ad; c++) begin
      mif.data_addr_ok = (c == ad);
      @(negedge clk);
      if (c == 0) begin
        check({nm, " wr"}, mif.data_wr, x_wstrb != 4'd0);
        check({nm, " size"}, mif.data_size, x_size);
        check({nm, " wstrb"}, mif.data_wstrb, x_wstrb);
        check({nm, " wdata"}, mif.data_wdata, x_wdata);
        check({nm, " addr"}, mif.data_addr, ins.ex_result);
      end
      if (stallreq) n_stall++;
      if (mif.data_req) n_req++;
      step();
    end
    mif.data_addr_ok = 1'b0;
    mif.data_data_ok = 1'b1;
    mif.data_rdata   = rd;
    @(negedge clk);
    if (stallreq) n_stall++;
    if (mif.data_req) n_req++;
    step();
    mif.data_data_ok = 1'b0;
    mif.data_rdata   = 32'hDEAD_BEEF;
    for (int c = 0; c <= hold; c++) begin
      ext_hold = (c < hold);
      @(negedge clk);
      if (stallreq) n_stall++;
      if (mif.data_req) n_req++;
      if (c == 0) begin
        w = wb_bus;
        check({nm, " rf_wdata"}, w.rf_wdata, x_rf);
      end
      step();
    end
    ext_hold = 1'b0;
    check({nm, " stall_cycles"}, n_stall, ad + 2);
    check({nm, " req_cycles"}, n_req, ad + 1);
    check({nm, " handshakes"}, n_hs - hs0, 1);
  endtask

  initial begin
    ex_mem_t alu;
    ex_mem_t ins;
    mem_wb_t w;
    rst = 1'b1; ex_bus = '0; ext_hold = 1'b0; force_bubble = 1'b0; chk_en = 1'b0;
    mif.data_addr_ok = 1'b0; mif.data_data_ok = 1'b0; mif.data_rdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    check("rst wb_bus", wb_bus, 136'd0);
    check("rst id_bus", id_bus, 136'd0);
    check("rst data_req", mif.data_req, 1'b0);
    check("rst stallreq", stallreq, 1'b0);
    check("rst data_wr", mif.data_wr, 1'b0);
    check("rst data_size", mif.data_size, 2'd0);
    check("rst data_wstrb", mif.data_wstrb, 4'd0);
    check("rst data_addr", mif.data_addr, 32'd0);
    check("rst data_wdata", mif.data_wdata, 32'd0);
    step();

    alu = '0;
    alu.rf_we = 1'b1; alu.rf_waddr = 5'd3; alu.ex_result = 32'h55; alu.pc = 32'h400;
    ex_bus = alu;
    step();
    ex_bus = '0;
    @(negedge clk);
    w = wb_bus;
    check("alu rf_wdata", w.rf_wdata, 32'h55);
    check("alu id rf_we", id_bus[103], 1'b1);
    check("alu data_req", mif.data_req, 1'b0);
    step();
    force_bubble = 1'b1;
    ex_bus = alu;
    step();
    force_bubble = 1'b0;
    ex_bus = '0;
    @(negedge clk);
    check("bubble wb_bus", wb_bus, 136'd0);
    step();

    do_mem("lw",  mk(T_W,  4'b0000, 32'h100, 32'h0), 0, 32'h1234_5678, 0, 32'h1234_5678, 2'd2, 4'b0000, 32'h0);
    do_mem("lb",  mk(T_B,  4'b0000, 32'h103, 32'h0), 0, 32'h80FF_0011, 0, 32'hFFFF_FF80, 2'd0, 4'b0000, 32'h0);
    do_mem("lbu", mk(T_BU, 4'b0000, 32'h103, 32'h0), 0, 32'h80FF_0011, 0, 32'h0000_0080, 2'd0, 4'b0000, 32'h0);
    do_mem("lh",  mk(T_H,  4'b0000, 32'h102, 32'h0), 0, 32'h8001_7FFF, 0, 32'hFFFF_8001, 2'd1, 4'b0000, 32'h0);
    do_mem("lhu", mk(T_HU, 4'b0000, 32'h100, 32'h0), 0, 32'h8001_7FFF, 0, 32'h0000_7FFF, 2'd1, 4'b0000, 32'h0);
    do_mem("sb",  mk(T_B,  4'b0010, 32'h101, 32'hAABB_CCDD), 0, 32'h0, 0, 32'h101, 2'd0, 4'b0010, 32'hDDDD_DDDD);
    do_mem("sh",  mk(T_H,  4'b1100, 32'h102, 32'hAABB_CCDD), 0, 32'h0, 0, 32'h102, 2'd1, 4'b1100, 32'hCCDD_CCDD);
    do_mem("sw",  mk(T_W,  4'b1111, 32'h104, 32'hAABB_CCDD), 0, 32'h0, 0, 32'h104, 2'd2, 4'b1111, 32'hAABB_CCDD);
    do_mem("lw_slow", mk(T_W, 4'b0000, 32'h108, 32'h0), 3, 32'h0BAD_F00D, 2, 32'h0BAD_F00D, 2'd2, 4'b0000, 32'h0);

    // reset while waiting for data, then a stray data_ok that must be ignored
    ex_bus = mk(T_W, 4'b0000, 32'h200, 32'h0);
    step();
    ex_bus = '0;
    mif.data_addr_ok = 1'b1;
    step();
    mif.data_addr_ok = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rstwait data_req", mif.data_req, 1'b0);
    check("rstwait stallreq", stallreq, 1'b0);
    ins = mk(T_W, 4'b0000, 32'h204, 32'h0);
    ex_bus = ins;
    mif.data_data_ok = 1'b1;
    mif.data_rdata = 32'hCAFE_F00D;
    step();
    ex_bus = '0;
    @(negedge clk);
    check("late data_req", mif.data_req, 1'b1);
    check("late stallreq", stallreq, 1'b1);
    step();
    mif.data_data_ok = 1'b0;
    mif.data_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("late still stalled", stallreq, 1'b1);
    w = wb_bus;
    check("late rf_wdata", w.rf_wdata, 32'h0);
    mif.data_addr_ok = 1'b1;
    step();
    mif.data_addr_ok = 1'b0;
    mif.data_data_ok = 1'b1;
    mif.data_rdata = 32'h0000_00AA;
    step();
    mif.data_data_ok = 1'b0;
    mif.data_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    w = wb_bus;
    check("after rst rf_wdata", w.rf_wdata, 32'h0000_00AA);
    check("after rst stallreq", stallreq, 1'b0);
    step();
    step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
